// File: rtl/phase_timer_pkg.sv
// Shared types, default parameters and arithmetic helpers for the phase timer.
package phase_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned PT_WIDTH    = 5;
    localparam int unsigned PT_EXT_STEP = 3;
    localparam int unsigned PT_MAX_EXT  = 10;

    // Unsigned a+b clamped to the largest value representable in 'width' bits.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int unsigned width
    );
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << width) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/phase_timer_if.sv
// Control/status bundle between the phase FSM (master) and a phase timer (slave).
interface phase_timer_if #(
    parameter int unsigned WIDTH = phase_timer_pkg::PT_WIDTH
);
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             tick;
    logic             hold;
    logic             extend;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             done;
    logic [WIDTH-1:0] ext_total;

    modport master (
        output load, load_data, tick, hold, extend,
        input  count, running, done, ext_total
    );

    modport slave (
        input  load, load_data, tick, hold, extend,
        output count, running, done, ext_total
    );
endinterface

// File: rtl/phase_timer_ext_budget.sv
// Combinational green-extension grant: min(EXT_STEP, remaining budget) when requested.
module ext_budget
    import phase_timer_pkg::*;
#(
    parameter int unsigned WIDTH    = PT_WIDTH,
    parameter int unsigned EXT_STEP = PT_EXT_STEP,
    parameter int unsigned MAX_EXT  = PT_MAX_EXT
) (
    input  logic             i_extend,
    input  logic [WIDTH-1:0] i_ext_total,
    output logic [WIDTH-1:0] o_grant
);

    logic [31:0] w_room;
    logic [31:0] w_step;

    always_comb begin
        w_room  = (MAX_EXT > 32'(i_ext_total)) ? (MAX_EXT - 32'(i_ext_total)) : 32'd0;
        w_step  = (w_room < EXT_STEP) ? w_room : EXT_STEP;
        o_grant = i_extend ? WIDTH'(w_step) : '0;
    end

endmodule

// File: rtl/phase_timer.sv
// Loadable tick-driven down-counter for one traffic phase, with hold and bounded extension.
module phase_timer
    import phase_timer_pkg::*;
#(
    parameter int unsigned WIDTH    = PT_WIDTH,
    parameter int unsigned EXT_STEP = PT_EXT_STEP,
    parameter int unsigned MAX_EXT  = PT_MAX_EXT
) (
    input logic         clk,
    input logic         rst,
    phase_timer_if.slave bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_ext_total;
    logic             r_running;
    logic             r_done;

    logic [WIDTH-1:0] w_grant;
    logic [WIDTH-1:0] w_next;
    logic             w_dec;

    ext_budget #(
        .WIDTH   (WIDTH),
        .EXT_STEP(EXT_STEP),
        .MAX_EXT (MAX_EXT)
    ) u_ext_budget (
        .i_extend   (bus.extend),
        .i_ext_total(r_ext_total),
        .o_grant    (w_grant)
    );

    assign w_dec = bus.tick & ~bus.hold;

    // r_count >= 1 throughout RUN, so decrementing first cannot underflow and
    // saturating afterwards equals saturating count+grant-tick as a whole.
    assign w_next = WIDTH'(sat_add(32'(r_count) - 32'(w_dec), 32'(w_grant), WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_ext_total <= '0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.load) begin
                r_ext_total <= '0;
                r_count     <= bus.load_data;
                if (bus.load_data != '0) begin
                    r_state   <= RUN;
                    r_running <= 1'b1;
                end else begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b1;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        r_running <= 1'b0;
                    end
                    RUN: begin
                        r_ext_total <= r_ext_total + w_grant;
                        r_count     <= w_next;
                        if (w_next == '0) begin
                            r_state   <= IDLE;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.count     = r_count;
    assign bus.running   = r_running;
    assign bus.done      = r_done;
    assign bus.ext_total = r_ext_total;

endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer: per-cycle expectations from a behavioural model plus directed checks.
module tb_phase_timer;

    localparam int unsigned W = 5;

    typedef struct packed {
        logic [W-1:0] count;
        logic         running;
        logic         done;
        logic [W-1:0] ext;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    phase_timer_if #(.WIDTH(W)) bus ();

    phase_timer #(.WIDTH(W), .EXT_STEP(3), .MAX_EXT(10)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    obs_t exp_q[$];
    obs_t act_q[$];
    int   total = 0;
    int   bad   = 0;

    int m_count = 0;
    int m_ext   = 0;
    bit m_run   = 1'b0;
    bit m_done  = 1'b0;

    // One clock of stimulus: model predicts, DUT is sampled 1 ns after the edge.
    task automatic drive(input bit r, input bit l, input int ld, input bit t, input bit h, input bit e);
        obs_t ex;
        obs_t ac;
        int   g;
        int   n;
        rst           = r;
        bus.load      = l;
        bus.load_data = W'(ld);
        bus.tick      = t;
        bus.hold      = h;
        bus.extend    = e;
        if (r) begin
            m_count = 0; m_ext = 0; m_run = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (l) begin
                m_ext = 0;
                m_count = ld;
                m_run = (ld != 0);
                m_done = (ld == 0);
            end else if (m_run) begin
                g = e ? ((10 - m_ext) < 3 ? (10 - m_ext) : 3) : 0;
                m_ext += g;
                n = m_count + g - ((t && !h) ? 1 : 0);
                if (n > 31) n = 31;
                m_count = n;
                if (n == 0) begin
                    m_run = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
        ex.count = W'(m_count); ex.running = m_run; ex.done = m_done; ex.ext = W'(m_ext);
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        ac.count = bus.count; ac.running = bus.running; ac.done = bus.done; ac.ext = bus.ext_total;
        act_q.push_back(ac);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        obs_t e, a;
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 9, 1'b1, 1'b0, 1'b1);
        idle(2);
        if (bus.count !== 5'd0 || bus.running !== 1'b0 || bus.done !== 1'b0 || bus.ext_total !== 5'd0) begin
            bad++;
            $display("FAIL reset_state: got cnt=%0d run=%0b done=%0b ext=%0d want 0 0 0 0",
                     bus.count, bus.running, bus.done, bus.ext_total);
        end
        total++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin
                bad++;
                $display("FAIL reset_sb: got cnt=%0d run=%0b done=%0b ext=%0d want cnt=%0d run=%0b done=%0b ext=%0d",
                         a.count, a.running, a.done, a.ext, e.count, e.running, e.done, e.ext);
            end
        end
    endtask

    task automatic test_countdown;
        obs_t e, a;
        int   ndone = 0;
        drive(1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 3; i++) begin
                drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
                ndone += int'(bus.done);
            end
            drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
            ndone += int'(bus.done);
        end
        total++;
        if (bus.count !== 5'd0 || bus.done !== 1'b1 || bus.running !== 1'b0) begin
            bad++;
            $display("FAIL countdown_expire: got cnt=%0d done=%0b run=%0b want 0 1 0", bus.count, bus.done, bus.running);
        end
        idle(3);
        ndone += int'(bus.done);
        total++;
        if (ndone != 1) begin
            bad++;
            $display("FAIL countdown_done_once: got %0d pulses want 1", ndone);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin
                bad++;
                $display("FAIL countdown_sb: got cnt=%0d run=%0b done=%0b ext=%0d want cnt=%0d run=%0b done=%0b ext=%0d",
                         a.count, a.running, a.done, a.ext, e.count, e.running, e.done, e.ext);
            end
        end
    endtask

    task automatic test_hold;
        obs_t e, a;
        drive(1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
            drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        end
        total++;
        if (bus.count !== 5'd3 || bus.running !== 1'b1) begin
            bad++;
            $display("FAIL hold_frozen: got cnt=%0d run=%0b want 3 1", bus.count, bus.running);
        end
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        total++;
        if (bus.done !== 1'b1 || bus.count !== 5'd0) begin
            bad++;
            $display("FAIL hold_resume_done: got done=%0b cnt=%0d want 1 0", bus.done, bus.count);
        end
        idle(1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin
                bad++;
                $display("FAIL hold_sb: got cnt=%0d run=%0b done=%0b ext=%0d want cnt=%0d run=%0b done=%0b ext=%0d",
                         a.count, a.running, a.done, a.ext, e.count, e.running, e.done, e.ext);
            end
        end
    endtask

    task automatic test_extend;
        obs_t e, a;
        drive(1'b0, 1'b1, 6, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        total++;
        if (bus.ext_total !== 5'd10 || bus.count !== 5'd16) begin
            bad++;
            $display("FAIL extend_budget: got ext=%0d cnt=%0d want 10 16", bus.ext_total, bus.count);
        end
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        total++;
        if (bus.ext_total !== 5'd10 || bus.count !== 5'd15) begin
            bad++;
            $display("FAIL extend_exhausted: got ext=%0d cnt=%0d want 10 15", bus.ext_total, bus.count);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin
                bad++;
                $display("FAIL extend_sb: got cnt=%0d run=%0b done=%0b ext=%0d want cnt=%0d run=%0b done=%0b ext=%0d",
                         a.count, a.running, a.done, a.ext, e.count, e.running, e.done, e.ext);
            end
        end
    endtask

    task automatic test_tick_extend_at_one;
        obs_t e, a;
        drive(1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        total++;
        if (bus.count !== 5'd3 || bus.done !== 1'b0 || bus.running !== 1'b1) begin
            bad++;
            $display("FAIL tick_extend_one: got cnt=%0d done=%0b run=%0b want 3 0 1", bus.count, bus.done, bus.running);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin
                bad++;
                $display("FAIL tick_ext_sb: got cnt=%0d run=%0b done=%0b ext=%0d want cnt=%0d run=%0b done=%0b ext=%0d",
                         a.count, a.running, a.done, a.ext, e.count, e.running, e.done, e.ext);
            end
        end
    endtask

    task automatic test_saturate;
        obs_t e, a;
        drive(1'b0, 1'b1, 30, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        total++;
        if (bus.count !== 5'd31 || bus.ext_total !== 5'd6) begin
            bad++;
            $display("FAIL saturate: got cnt=%0d ext=%0d want 31 6", bus.count, bus.ext_total);
        end
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin
                bad++;
                $display("FAIL saturate_sb: got cnt=%0d run=%0b done=%0b ext=%0d want cnt=%0d run=%0b done=%0b ext=%0d",
                         a.count, a.running, a.done, a.ext, e.count, e.running, e.done, e.ext);
            end
        end
    endtask

    task automatic test_rst_mid_run;
        obs_t e, a;
        drive(1'b0, 1'b1, 7, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        total++;
        if (bus.count !== 5'd7) begin
            bad++;
            $display("FAIL rst_precond: got cnt=%0d want 7", bus.count);
        end
        drive(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        total++;
        if (bus.count !== 5'd0 || bus.running !== 1'b0 || bus.done !== 1'b0 || bus.ext_total !== 5'd0) begin
            bad++;
            $display("FAIL rst_mid_run: got cnt=%0d run=%0b done=%0b ext=%0d want 0 0 0 0",
                     bus.count, bus.running, bus.done, bus.ext_total);
        end
        idle(2);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin
                bad++;
                $display("FAIL rst_sb: got cnt=%0d run=%0b done=%0b ext=%0d want cnt=%0d run=%0b done=%0b ext=%0d",
                         a.count, a.running, a.done, a.ext, e.count, e.running, e.done, e.ext);
            end
        end
    endtask

    task automatic test_zero_load;
        obs_t e, a;
        drive(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus.done !== 1'b1 || bus.running !== 1'b0 || bus.count !== 5'd0) begin
            bad++;
            $display("FAIL zero_load_pulse: got done=%0b run=%0b cnt=%0d want 1 0 0", bus.done, bus.running, bus.count);
        end
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1);
        total++;
        if (bus.done !== 1'b0 || bus.count !== 5'd0 || bus.ext_total !== 5'd0) begin
            bad++;
            $display("FAIL idle_ignore: got done=%0b cnt=%0d ext=%0d want 0 0 0", bus.done, bus.count, bus.ext_total);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin
                bad++;
                $display("FAIL zero_sb: got cnt=%0d run=%0b done=%0b ext=%0d want cnt=%0d run=%0b done=%0b ext=%0d",
                         a.count, a.running, a.done, a.ext, e.count, e.running, e.done, e.ext);
            end
        end
    endtask

    task automatic test_back_to_back;
        obs_t e, a;
        drive(1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 12, 1'b1, 1'b0, 1'b1);
        total++;
        if (bus.count !== 5'd12 || bus.ext_total !== 5'd0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reload_run: got cnt=%0d ext=%0d done=%0b want 12 0 0", bus.count, bus.ext_total, bus.done);
        end
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 0, 1'(k % 2), 1'b0, 1'(k == 2));
        drive(1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        idle(2);
        for (int k = 0; k < 12; k++) drive(1'b0, 1'(k == 0), 3, 1'b1, 1'(k == 5), 1'(k == 2));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin
                bad++;
                $display("FAIL b2b_sb: got cnt=%0d run=%0b done=%0b ext=%0d want cnt=%0d run=%0b done=%0b ext=%0d",
                         a.count, a.running, a.done, a.ext, e.count, e.running, e.done, e.ext);
            end
        end
    endtask

    initial begin
        bus.load = 1'b0; bus.load_data = '0; bus.tick = 1'b0; bus.hold = 1'b0; bus.extend = 1'b0;
        test_reset;
        test_countdown;
        test_hold;
        test_extend;
        test_tick_extend_at_one;
        test_saturate;
        test_rst_mid_run;
        test_zero_load;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
